// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares one single-ported RAM between the instruction-fetch port (IF stage)
// and the load/store port (MEM stage) of the core. Only one access is in
// flight at a time, and data always wins over fetch. Each access ends with a
// one-cycle valid pulse back to its requester. Per-requester stall outputs go
// to the pause controller.
//
// Transaction timing (grant decided combinationally in cycle t, in IDLE):
//   t+1             ISSUE : ram_en_o high for exactly one cycle
//   t+2 .. t+1+LAT  WAIT  : read latency countdown (skipped for stores)
//   t+2+LAT / t+2         : requester valid pulse, FSM back in IDLE
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   inst_req_i/addr_i        fetch request, held until inst_valid_o
//   inst_data_o/valid_o      fetched word and its completion pulse
//   inst_stall_o             inst_req_i & ~inst_valid_o
//   flush_i                  branch flush, drops the pending/outstanding fetch
//   data_req_i/we_i/addr_i/
//   wdata_i/sel_i            load/store request, held until data_valid_o
//   data_rdata_o/valid_o     load data and completion pulse
//   data_stall_o             data_req_i & ~data_valid_o
//   ram_en_o/we_o/addr_o/
//   wdata_o/sel_o            registered RAM command, zero outside ISSUE
//   ram_rdata_i              RAM read data, valid RAM_LAT cycles after ram_en_o
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [DATA_W-1:0] inst_data_o,
  output logic              inst_valid_o,
  output logic              inst_stall_o,
  input  logic              flush_i,

  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  input  logic [3:0]        data_sel_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_valid_o,
  output logic              data_stall_o,

  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic [3:0]        ram_sel_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  // Counter only has to hold RAM_LAT down to 1.
  localparam int CNT_W = (RAM_LAT < 2) ? 1 : $clog2(RAM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  typedef enum logic {
    OWN_INST,
    OWN_DATA
  } owner_t;

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_t            state_q,      state_d;
  owner_t            owner_q,      owner_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic              dropped_q,    dropped_d;   // in-flight fetch was flushed
  logic              inst_valid_q, inst_valid_d;

  logic              ram_en_d;
  logic              ram_we_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_d;
  logic [3:0]        ram_sel_d;
  logic              data_valid_d;
  logic [DATA_W-1:0] inst_data_d;
  logic [DATA_W-1:0] data_rdata_d;

  logic              grant_data;
  logic              grant_inst;
  logic              last_wait;

  // A requester is never re-granted in the cycle its own valid pulses: it
  // is still holding req that cycle only because it has not seen valid yet.
  assign grant_data = data_req_i & ~data_valid_o;
  assign grant_inst = inst_req_i & ~inst_valid_q & ~flush_i;
  assign last_wait  = (cnt_q == CNT_W'(1));

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    dropped_d    = dropped_q;
    inst_valid_d = 1'b0;
    data_valid_d = 1'b0;
    inst_data_d  = inst_data_o;
    data_rdata_d = data_rdata_o;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = '0;
    ram_wdata_d  = '0;
    ram_sel_d    = 4'b0000;

    // A flush while a fetch is on the RAM only marks it; the read still
    // runs to completion so the FSM timing never depends on flush_i.
    if (flush_i && owner_q == OWN_INST && state_q != S_IDLE) begin
      dropped_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (grant_data) begin
          owner_d     = OWN_DATA;
          state_d     = S_ISSUE;
          ram_en_d    = 1'b1;
          ram_we_d    = data_we_i;
          ram_addr_d  = data_addr_i;
          ram_wdata_d = data_wdata_i;
          ram_sel_d   = data_sel_i;
        end else if (grant_inst) begin
          owner_d     = OWN_INST;
          state_d     = S_ISSUE;
          dropped_d   = 1'b0;
          ram_en_d    = 1'b1;
          ram_addr_d  = inst_addr_i;
          ram_sel_d   = 4'b1111;
        end
      end

      S_ISSUE: begin
        // Only the data port can issue a store; it completes without a
        // read-latency wait.
        if (ram_we_o) begin
          state_d      = S_IDLE;
          data_valid_d = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(RAM_LAT);
        end
      end

      S_WAIT: begin
        if (last_wait) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (owner_q == OWN_DATA) begin
            data_valid_d = 1'b1;
            data_rdata_d = ram_rdata_i;
          end else if (!(dropped_q || flush_i)) begin
            inst_valid_d = 1'b1;
            inst_data_d  = ram_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_INST;
      cnt_q        <= '0;
      dropped_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      data_valid_o <= 1'b0;
      inst_data_o  <= '0;
      data_rdata_o <= '0;
      ram_en_o     <= 1'b0;
      ram_we_o     <= 1'b0;
      ram_addr_o   <= '0;
      ram_wdata_o  <= '0;
      ram_sel_o    <= 4'b0000;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      dropped_q    <= dropped_d;
      inst_valid_q <= inst_valid_d;
      data_valid_o <= data_valid_d;
      inst_data_o  <= inst_data_d;
      data_rdata_o <= data_rdata_d;
      ram_en_o     <= ram_en_d;
      ram_we_o     <= ram_we_d;
      ram_addr_o   <= ram_addr_d;
      ram_wdata_o  <= ram_wdata_d;
      ram_sel_o    <= ram_sel_d;
    end
  end

  // -------------------------------------------------------------------------
  // Combinational outputs
  // -------------------------------------------------------------------------
  // A flush arriving in the very cycle of the fetch pulse still kills it.
  assign inst_valid_o = inst_valid_q & ~flush_i;

  // Stalls are held low during reset so the pause controller sees a clean
  // all-zero interface.
  assign inst_stall_o = inst_req_i & ~inst_valid_o & ~rst;
  assign data_stall_o = data_req_i & ~data_valid_o & ~rst;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
//
// Directed bench for ram_port_arbiter. Instance u_a uses RAM_LAT=1, instance
// u_b uses RAM_LAT=3. The bench plays the RAM: ram_rdata is driven with the
// expected word only in the cycle the arbiter must sample it, and with a
// junk pattern otherwise. Inputs change 1 time unit after the rising edge;
// outputs are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;

  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic clk;
  logic rst;

  int n_cmp  = 0;
  int n_fail = 0;

  // Instance A (RAM_LAT = 1)
  logic        a_inst_req, a_inst_valid, a_inst_stall, a_flush;
  logic [31:0] a_inst_addr, a_inst_data;
  logic        a_data_req, a_data_we, a_data_valid, a_data_stall;
  logic [31:0] a_data_addr, a_data_wdata, a_data_rdata;
  logic [3:0]  a_data_sel;
  logic        a_ram_en, a_ram_we;
  logic [31:0] a_ram_addr, a_ram_wdata, a_ram_rdata;
  logic [3:0]  a_ram_sel;

  // Instance B (RAM_LAT = 3)
  logic        b_inst_req, b_inst_valid, b_inst_stall, b_flush;
  logic [31:0] b_inst_addr, b_inst_data;
  logic        b_data_req, b_data_we, b_data_valid, b_data_stall;
  logic [31:0] b_data_addr, b_data_wdata, b_data_rdata;
  logic [3:0]  b_data_sel;
  logic        b_ram_en, b_ram_we;
  logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;
  logic [3:0]  b_ram_sel;

  ram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1)) u_a (
    .clk          (clk),
    .rst          (rst),
    .inst_req_i   (a_inst_req),
    .inst_addr_i  (a_inst_addr),
    .inst_data_o  (a_inst_data),
    .inst_valid_o (a_inst_valid),
    .inst_stall_o (a_inst_stall),
    .flush_i      (a_flush),
    .data_req_i   (a_data_req),
    .data_we_i    (a_data_we),
    .data_addr_i  (a_data_addr),
    .data_wdata_i (a_data_wdata),
    .data_sel_i   (a_data_sel),
    .data_rdata_o (a_data_rdata),
    .data_valid_o (a_data_valid),
    .data_stall_o (a_data_stall),
    .ram_en_o     (a_ram_en),
    .ram_we_o     (a_ram_we),
    .ram_addr_o   (a_ram_addr),
    .ram_wdata_o  (a_ram_wdata),
    .ram_sel_o    (a_ram_sel),
    .ram_rdata_i  (a_ram_rdata)
  );

  ram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(3)) u_b (
    .clk          (clk),
    .rst          (rst),
    .inst_req_i   (b_inst_req),
    .inst_addr_i  (b_inst_addr),
    .inst_data_o  (b_inst_data),
    .inst_valid_o (b_inst_valid),
    .inst_stall_o (b_inst_stall),
    .flush_i      (b_flush),
    .data_req_i   (b_data_req),
    .data_we_i    (b_data_we),
    .data_addr_i  (b_data_addr),
    .data_wdata_i (b_data_wdata),
    .data_sel_i   (b_data_sel),
    .data_rdata_o (b_data_rdata),
    .data_valid_o (b_data_valid),
    .data_stall_o (b_data_stall),
    .ram_en_o     (b_ram_en),
    .ram_we_o     (b_ram_we),
    .ram_addr_o   (b_ram_addr),
    .ram_wdata_o  (b_ram_wdata),
    .ram_sel_o    (b_ram_sel),
    .ram_rdata_i  (b_ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start of the next cycle: just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle comparison point.
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_a();
    a_inst_req = 1'b0; a_inst_addr = '0; a_flush = 1'b0;
    a_data_req = 1'b0; a_data_we = 1'b0; a_data_addr = '0;
    a_data_wdata = '0; a_data_sel = 4'b0000;
  endtask

  task automatic idle_b();
    b_inst_req = 1'b0; b_inst_addr = '0; b_flush = 1'b0;
    b_data_req = 1'b0; b_data_we = 1'b0; b_data_addr = '0;
    b_data_wdata = '0; b_data_sel = 4'b0000;
  endtask

  initial begin
    rst = 1'b1;
    idle_a();
    idle_b();
    a_ram_rdata = JUNK;
    b_ram_rdata = JUNK;

    // ---------------- Reset state ----------------
    step();
    step();
    sample();
    check("rst_ram_en",     32'(a_ram_en),     32'd0);
    check("rst_ram_addr",   a_ram_addr,        32'd0);
    check("rst_inst_valid", 32'(a_inst_valid), 32'd0);
    check("rst_data_valid", 32'(a_data_valid), 32'd0);
    check("rst_data_rdata", a_data_rdata,      32'd0);
    check("rst_b_ram_en",   32'(b_ram_en),     32'd0);

    // ---------------- 1: single fetch ----------------
    step(); rst = 1'b0;                                    // cyc0
    a_inst_req = 1'b1; a_inst_addr = 32'h1C00_0000;
    sample();
    check("t1_c0_stall",  32'(a_inst_stall), 32'd1);
    check("t1_c0_ram_en", 32'(a_ram_en),     32'd0);
    step(); sample();                                      // cyc1
    check("t1_c1_ram_en",   32'(a_ram_en),   32'd1);
    check("t1_c1_ram_addr", a_ram_addr,      32'h1C00_0000);
    check("t1_c1_ram_we",   32'(a_ram_we),   32'd0);
    check("t1_c1_ram_sel",  32'(a_ram_sel),  32'hF);
    check("t1_c1_stall",    32'(a_inst_stall), 32'd1);
    step(); a_ram_rdata = 32'h0280_0421; sample();         // cyc2
    check("t1_c2_ram_en",  32'(a_ram_en),     32'd0);
    check("t1_c2_valid",   32'(a_inst_valid), 32'd0);
    check("t1_c2_stall",   32'(a_inst_stall), 32'd1);
    step(); a_ram_rdata = JUNK; sample();                  // cyc3
    check("t1_c3_valid",   32'(a_inst_valid), 32'd1);
    check("t1_c3_data",    a_inst_data,       32'h0280_0421);
    check("t1_c3_stall",   32'(a_inst_stall), 32'd0);
    check("t1_c3_ram_en",  32'(a_ram_en),     32'd0);
    step(); idle_a(); sample();                            // cyc4
    check("t1_c4_valid",   32'(a_inst_valid), 32'd0);
    check("t1_c4_ram_en",  32'(a_ram_en),     32'd0);
    check("t1_c4_data",    a_inst_data,       32'h0280_0421);

    // ---------------- 2: fetch and load together ----------------
    step();                                                // cyc0
    a_inst_req = 1'b1; a_inst_addr = 32'h1C00_0004;
    a_data_req = 1'b1; a_data_we = 1'b0; a_data_addr = 32'h0000_0100;
    a_data_sel = 4'b1111;
    sample();
    check("t2_c0_istall", 32'(a_inst_stall), 32'd1);
    check("t2_c0_dstall", 32'(a_data_stall), 32'd1);
    step(); sample();                                      // cyc1
    check("t2_c1_ram_en",   32'(a_ram_en), 32'd1);
    check("t2_c1_ram_addr", a_ram_addr,    32'h0000_0100);
    step(); a_ram_rdata = 32'h1111_2222; sample();         // cyc2
    step(); a_ram_rdata = JUNK; sample();                  // cyc3
    check("t2_c3_dvalid",  32'(a_data_valid), 32'd1);
    check("t2_c3_drdata",  a_data_rdata,      32'h1111_2222);
    check("t2_c3_dstall",  32'(a_data_stall), 32'd0);
    check("t2_c3_ivalid",  32'(a_inst_valid), 32'd0);
    check("t2_c3_ram_en",  32'(a_ram_en),     32'd0);
    step(); a_data_req = 1'b0; a_data_addr = '0; a_data_sel = '0; sample();  // cyc4
    check("t2_c4_ram_en",   32'(a_ram_en),     32'd1);
    check("t2_c4_ram_addr", a_ram_addr,        32'h1C00_0004);
    check("t2_c4_ram_sel",  32'(a_ram_sel),    32'hF);
    check("t2_c4_dvalid",   32'(a_data_valid), 32'd0);
    step(); a_ram_rdata = 32'h3333_4444; sample();         // cyc5
    check("t2_c5_ivalid", 32'(a_inst_valid), 32'd0);
    step(); a_ram_rdata = JUNK; sample();                  // cyc6
    check("t2_c6_ivalid", 32'(a_inst_valid), 32'd1);
    check("t2_c6_idata",  a_inst_data,       32'h3333_4444);
    step(); idle_a(); sample();                            // cyc7
    check("t2_c7_ivalid", 32'(a_inst_valid), 32'd0);

    // ---------------- 3: store ----------------
    step();                                                // cyc0
    a_data_req = 1'b1; a_data_we = 1'b1; a_data_addr = 32'h0000_0200;
    a_data_wdata = 32'h0000_1234; a_data_sel = 4'b0011;
    sample();
    step(); sample();                                      // cyc1
    check("t3_c1_ram_en",    32'(a_ram_en),  32'd1);
    check("t3_c1_ram_we",    32'(a_ram_we),  32'd1);
    check("t3_c1_ram_sel",   32'(a_ram_sel), 32'h3);
    check("t3_c1_ram_addr",  a_ram_addr,     32'h0000_0200);
    check("t3_c1_ram_wdata", a_ram_wdata,    32'h0000_1234);
    step(); sample();                                      // cyc2
    check("t3_c2_dvalid",    32'(a_data_valid), 32'd1);
    check("t3_c2_ram_en",    32'(a_ram_en),     32'd0);
    check("t3_c2_ram_we",    32'(a_ram_we),     32'd0);
    check("t3_c2_ram_sel",   32'(a_ram_sel),    32'h0);
    check("t3_c2_ram_addr",  a_ram_addr,        32'd0);
    check("t3_c2_ram_wdata", a_ram_wdata,       32'd0);
    check("t3_c2_drdata",    a_data_rdata,      32'h1111_2222);
    step(); idle_a(); sample();                            // cyc3
    check("t3_c3_dvalid", 32'(a_data_valid), 32'd0);
    check("t3_c3_ram_en", 32'(a_ram_en),     32'd0);

    // ---------------- 4: flushed fetch, then re-fetch ----------------
    step();                                                // cyc0
    a_inst_req = 1'b1; a_inst_addr = 32'h1C00_0008;
    sample();
    step(); sample();                                      // cyc1
    check("t4_c1_ram_en",   32'(a_ram_en), 32'd1);
    check("t4_c1_ram_addr", a_ram_addr,    32'h1C00_0008);
    step(); a_flush = 1'b1; a_ram_rdata = 32'h5555_6666; sample();  // cyc2
    check("t4_c2_ivalid", 32'(a_inst_valid), 32'd0);
    check("t4_c2_stall",  32'(a_inst_stall), 32'd1);
    step(); a_flush = 1'b0; a_ram_rdata = JUNK;            // cyc3
    a_inst_addr = 32'h1C00_0100;
    sample();
    check("t4_c3_ivalid", 32'(a_inst_valid), 32'd0);
    check("t4_c3_stall",  32'(a_inst_stall), 32'd1);
    check("t4_c3_ram_en", 32'(a_ram_en),     32'd0);
    step(); sample();                                      // cyc4
    check("t4_c4_ram_en",   32'(a_ram_en),     32'd1);
    check("t4_c4_ram_addr", a_ram_addr,        32'h1C00_0100);
    check("t4_c4_ivalid",   32'(a_inst_valid), 32'd0);
    step(); a_ram_rdata = 32'h7777_8888; sample();         // cyc5
    step(); a_ram_rdata = JUNK; sample();                  // cyc6
    check("t4_c6_ivalid", 32'(a_inst_valid), 32'd1);
    check("t4_c6_idata",  a_inst_data,       32'h7777_8888);
    step(); idle_a(); sample();                            // cyc7

    // ---------------- 5: reset mid-load ----------------
    step();                                                // cyc0
    a_data_req = 1'b1; a_data_we = 1'b0; a_data_addr = 32'h0000_0300;
    a_data_sel = 4'b1111;
    sample();
    step(); sample();                                      // cyc1
    check("t5_c1_ram_en", 32'(a_ram_en), 32'd1);
    step(); rst = 1'b1; a_ram_rdata = 32'h9999_AAAA; sample();  // cyc2
    step(); rst = 1'b0; a_ram_rdata = JUNK; idle_a(); sample(); // cyc3
    check("t5_c3_ram_en",    32'(a_ram_en),     32'd0);
    check("t5_c3_ram_we",    32'(a_ram_we),     32'd0);
    check("t5_c3_ram_addr",  a_ram_addr,        32'd0);
    check("t5_c3_ram_sel",   32'(a_ram_sel),    32'h0);
    check("t5_c3_dvalid",    32'(a_data_valid), 32'd0);
    check("t5_c3_ivalid",    32'(a_inst_valid), 32'd0);
    check("t5_c3_drdata",    a_data_rdata,      32'd0);
    check("t5_c3_idata",     a_inst_data,       32'd0);
    check("t5_c3_dstall",    32'(a_data_stall), 32'd0);
    step();                                                // cyc4
    a_data_req = 1'b1; a_data_addr = 32'h0000_0304; a_data_sel = 4'b1111;
    sample();
    check("t5_c4_dvalid", 32'(a_data_valid), 32'd0);
    check("t5_c4_ram_en", 32'(a_ram_en),     32'd0);
    step(); sample();                                      // cyc5
    check("t5_c5_ram_en",   32'(a_ram_en), 32'd1);
    check("t5_c5_ram_addr", a_ram_addr,    32'h0000_0304);
    step(); a_ram_rdata = 32'h1234_5678; sample();         // cyc6
    check("t5_c6_dvalid", 32'(a_data_valid), 32'd0);
    step(); a_ram_rdata = JUNK; sample();                  // cyc7
    check("t5_c7_dvalid", 32'(a_data_valid), 32'd1);
    check("t5_c7_drdata", a_data_rdata,      32'h1234_5678);
    step(); idle_a(); sample();                            // cyc8

    // ---------------- 6: RAM_LAT = 3 load ----------------
    step();                                                // cyc0
    b_data_req = 1'b1; b_data_we = 1'b0; b_data_addr = 32'h0000_0040;
    b_data_sel = 4'b1111;
    sample();
    step(); sample();                                      // cyc1
    check("t6_c1_ram_en",   32'(b_ram_en), 32'd1);
    check("t6_c1_ram_addr", b_ram_addr,    32'h0000_0040);
    step(); sample();                                      // cyc2
    check("t6_c2_ram_en", 32'(b_ram_en), 32'd0);
    step(); sample();                                      // cyc3
    check("t6_c3_dvalid", 32'(b_data_valid), 32'd0);
    step(); b_ram_rdata = 32'hDEAD_BEEF; sample();         // cyc4
    check("t6_c4_dvalid", 32'(b_data_valid), 32'd0);
    check("t6_c4_dstall", 32'(b_data_stall), 32'd1);
    step(); b_ram_rdata = JUNK; sample();                  // cyc5
    check("t6_c5_dvalid", 32'(b_data_valid), 32'd1);
    check("t6_c5_drdata", b_data_rdata,      32'hDEAD_BEEF);
    check("t6_c5_dstall", 32'(b_data_stall), 32'd0);
    step(); idle_b(); sample();                            // cyc6
    check("t6_c6_dvalid", 32'(b_data_valid), 32'd0);
    check("t6_c6_drdata", b_data_rdata,      32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
